// File: rtl/reg_file_wr_arbiter_pkg.sv
// Shared register-file write-port definitions: widths, depth, FSM encoding and
// arbitration pointer values.
package reg_file_wr_arbiter_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam logic PRIO_A = 1'b0;
   localparam logic PRIO_B = 1'b1;

   // After a grant the pointer moves to the side that was not served.
   function automatic logic next_prio(input logic [1:0] gnt, input logic prio);
      if (gnt[0])      return PRIO_B;
      else if (gnt[1]) return PRIO_A;
      else             return prio;
   endfunction

endpackage

// File: rtl/reg_file_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// side named by prio.
module rr_arb2
   import reg_file_wr_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);

   assign gnt[0] = req[0] & (~req[1] | (prio == PRIO_A));
   assign gnt[1] = req[1] & (~req[0] | (prio == PRIO_B));

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Register-file write port: clears every register after reset or clear_req,
// then arbitrates two requesters round-robin onto one registered write port.
module reg_file_wr_arbiter #(
   parameter int DATA_W = reg_file_wr_arbiter_pkg::DATA_W,
   parameter int ADDR_W = reg_file_wr_arbiter_pkg::ADDR_W,
   parameter int DEPTH  = reg_file_wr_arbiter_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              clear_req,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              wena,
   output logic              init_done
);

   import reg_file_wr_arbiter_pkg::*;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              prio;
   logic              run_ok;
   logic [1:0]        req;
   logic [1:0]        gnt;

   // A clear request suppresses grants in the very cycle it arrives.
   assign run_ok = (state == RUN) && !clear_req;
   assign req    = {b_valid, a_valid} & {2{run_ok}};

   rr_arb2 u_arb (
      .req  (req),
      .prio (prio),
      .gnt  (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= CLEAR;
         cnt       <= '0;
         prio      <= PRIO_A;
         wena      <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         init_done <= 1'b0;
      end else begin
         wena <= 1'b0;
         if (state == CLEAR) begin
            wena  <= 1'b1;
            waddr <= cnt;
            wdata <= '0;
            if (cnt == LAST) begin
               state     <= RUN;
               init_done <= 1'b1;
               cnt       <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (clear_req) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_done <= 1'b0;
         end else if (|gnt) begin
            wena  <= 1'b1;
            waddr <= gnt[0] ? a_addr : b_addr;
            wdata <= gnt[0] ? a_data : b_data;
            prio  <= next_prio(gnt, prio);
         end
      end
   end

endmodule
